// File: rtl/montgomery_operand_loader.sv
// montgomery_operand_loader
// Bridges 32-bit register commands to the wide Montgomery core: assembles the
// A/B/M operands word by word, launches the core, captures its result and
// returns it one word at a time for register readback.
module montgomery_operand_loader #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 1024,
  localparam int WORDS = OP_W / DATA_W,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic [OP_W-1:0]   core_a,
  output logic [OP_W-1:0]   core_b,
  output logic [OP_W-1:0]   core_m,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OP_W-1:0]   core_result,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              status_busy,
  output logic              status_done,
  output logic              err_overflow,
  output logic              err_incomplete
);

  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_reg;
  logic                core_start_reg;
  logic                err_overflow_reg;
  logic                err_incomplete_reg;
  logic [OP_W-1:0]     result_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  logic                cmd_fire;
  logic                clear_fire;
  logic                start_fire;
  logic                done_fire;
  logic [2:0]          load_fire;
  logic [2:0]          op_full;
  logic                load_any;
  logic                load_ovf;

  // Commands are only taken outside RUN; a command arriving in RUN is dropped.
  assign cmd_ready  = (state_reg != S_RUN);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign clear_fire = cmd_fire && (cmd_op == OP_CLEAR);
  assign start_fire = cmd_fire && (cmd_op == OP_START);
  assign done_fire  = core_done && (state_reg == S_RUN);

  // One shift register and word counter per operand (0=A, 1=B, 2=M).
  for (genvar gi = 0; gi < 3; gi++) begin : gen_op
    logic [OP_W-1:0]  shreg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             full;

    assign full          = (cnt_reg == CNT_FULL);
    assign load_fire[gi] = cmd_fire && (cmd_op == 3'(gi));

    // New words enter at the top so the first word written ends up as the LSW.
    always_ff @(posedge clk) begin
      if (reset) begin
        shreg_reg <= '0;
        cnt_reg   <= '0;
      end else if (clear_fire) begin
        shreg_reg <= '0;
        cnt_reg   <= '0;
      end else if (done_fire) begin
        cnt_reg   <= '0;
      end else if (load_fire[gi] && !full) begin
        shreg_reg <= {cmd_data, shreg_reg[OP_W-1:DATA_W]};
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

  assign op_full  = {gen_op[2].full, gen_op[1].full, gen_op[0].full};
  assign load_any = |load_fire;
  assign load_ovf = |(load_fire & op_full);

  assign core_a = gen_op[0].shreg_reg;
  assign core_b = gen_op[1].shreg_reg;
  assign core_m = gen_op[2].shreg_reg;

  // Control FSM, sticky error flags, result capture and registered readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      core_start_reg     <= 1'b0;
      err_overflow_reg   <= 1'b0;
      err_incomplete_reg <= 1'b0;
      result_reg         <= '0;
      rd_data_reg        <= '0;
    end else begin
      core_start_reg <= 1'b0;
      rd_data_reg    <= result_reg[rd_idx*DATA_W +: DATA_W];

      if (load_ovf) begin
        err_overflow_reg <= 1'b1;
      end

      unique case (state_reg)
        S_IDLE, S_DONE: begin
          if (clear_fire) begin
            err_overflow_reg   <= 1'b0;
            err_incomplete_reg <= 1'b0;
            state_reg          <= S_IDLE;
          end else if (start_fire) begin
            // A start with any operand short of WORDS words is refused.
            if (&op_full) begin
              state_reg      <= S_RUN;
              core_start_reg <= 1'b1;
            end else begin
              err_incomplete_reg <= 1'b1;
            end
          end else if (load_any) begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          if (done_fire) begin
            result_reg <= core_result;
            state_reg  <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign core_start     = core_start_reg;
  assign rd_data        = rd_data_reg;
  assign status_busy    = (state_reg == S_RUN);
  assign status_done    = (state_reg == S_DONE);
  assign err_overflow   = err_overflow_reg;
  assign err_incomplete = err_incomplete_reg;

endmodule

// File: tb/tb_montgomery_operand_loader.sv
// tb_montgomery_operand_loader
// Directed bench for the operand loader at OP_W=128 (four 32-bit words).
module tb_montgomery_operand_loader;

  localparam int DATA_W = 32;
  localparam int OP_W   = 128;

  logic              tb_ACLK;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic [OP_W-1:0]   core_a, core_b, core_m;
  logic              core_start;
  logic              core_done;
  logic [OP_W-1:0]   core_result;
  logic [1:0]        rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              status_busy, status_done, err_overflow, err_incomplete;

  int n_cmp = 0;
  int n_bad = 0;

  montgomery_operand_loader #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(tb_ACLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .core_a(core_a), .core_b(core_b), .core_m(core_m), .core_start(core_start),
    .core_done(core_done), .core_result(core_result),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .status_busy(status_busy), .status_done(status_done),
    .err_overflow(err_overflow), .err_incomplete(err_incomplete)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  // Flags packed as {core_start, status_busy, status_done, err_overflow, err_incomplete}.
  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [4:0] flags();
    return {core_start, status_busy, status_done, err_overflow, err_incomplete};
  endfunction

  task automatic chk(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    core_done = 1'b0; core_result = '0; rd_idx = '0;

    for (int i = 0; i < 4; i++) begin
      vecs[i]     = '{3'd0, 32'(i + 1), 5'b00000};
      vecs[i + 4] = '{3'd1, 32'(i + 5), 5'b00000};
      vecs[i + 8] = '{3'd2, 32'(i + 9), 5'b00000};
    end
    vecs[12] = '{3'd3, 32'h0, 5'b11000};

    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("reset_flags", 128'(flags()), 128'(5'b00000));
    chk("reset_ready", 128'(cmd_ready), 128'(1'b1));
    chk("reset_core_a", core_a, 128'h0);

    // Table: load A, B, M and start
    for (int i = 0; i < 13; i++) begin
      do_cmd(vecs[i].op, vecs[i].data);
      chk($sformatf("vec%0d_flags", i), 128'(flags()), 128'(vecs[i].exp_flags));
    end
    chk("run_core_a", core_a, 128'h00000004_00000003_00000002_00000001);
    chk("run_core_b", core_b, 128'h00000008_00000007_00000006_00000005);
    chk("run_core_m", core_m, 128'h0000000C_0000000B_0000000A_00000009);
    chk("run_ready", 128'(cmd_ready), 128'(1'b0));

    // Load attempted in RUN is dropped: no overflow, start pulse ends
    do_cmd(3'd0, 32'h99);
    chk("run_drop_flags", 128'(flags()), 128'(5'b01000));
    chk("run_drop_core_a", core_a, 128'h00000004_00000003_00000002_00000001);

    // core_done together with a clear: clear dropped, done processed
    core_done   = 1'b1;
    core_result = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    cmd_valid   = 1'b1; cmd_op = 3'd4;
    step();
    core_done = 1'b0; cmd_valid = 1'b0; core_result = '0;
    chk("done_flags", 128'(flags()), 128'(5'b00100));
    chk("done_core_a_kept", core_a, 128'h00000004_00000003_00000002_00000001);

    rd_idx = 2'd0; step();
    chk("rd_idx0", 128'(rd_data), 128'(32'hAAAAAAAA));
    rd_idx = 2'd3; step();
    chk("rd_idx3", 128'(rd_data), 128'(32'hDDDDDDDD));

    // Load in DONE leaves DONE, result still readable
    rd_idx = 2'd2;
    do_cmd(3'd0, 32'h11);
    chk("load_in_done_flags", 128'(flags()), 128'(5'b00000));
    chk("load_in_done_rd", 128'(rd_data), 128'(32'hCCCCCCCC));
    chk("load_in_done_core_a", core_a, 128'h00000011_00000004_00000003_00000002);

    // Overflow: five A loads, then clear
    do_cmd(3'd4, 32'h0);
    for (int i = 0; i < 5; i++) do_cmd(3'd0, 32'(16 + i));
    chk("ovf_flag", 128'(err_overflow), 128'(1'b1));
    chk("ovf_core_a", core_a, 128'h00000013_00000012_00000011_00000010);
    do_cmd(3'd4, 32'h0);
    chk("clear_ovf", 128'(err_overflow), 128'(1'b0));
    chk("clear_core_a", core_a, 128'h0);
    do_cmd(3'd0, 32'h55);
    chk("clear_cnt_a", core_a, 128'h00000055_00000000_00000000_00000000);
    chk("clear_cnt_no_ovf", 128'(err_overflow), 128'(1'b0));

    // Incomplete start: only three B words
    do_cmd(3'd4, 32'h0);
    for (int i = 0; i < 4; i++) do_cmd(3'd0, 32'(i));
    for (int i = 0; i < 3; i++) do_cmd(3'd1, 32'(i));
    for (int i = 0; i < 4; i++) do_cmd(3'd2, 32'(i));
    do_cmd(3'd3, 32'h0);
    chk("incomplete_flags", 128'(flags()), 128'(5'b00001));
    step();
    chk("incomplete_no_start", 128'(flags()), 128'(5'b00001));

    // Complete B, start, then reset mid-RUN
    do_cmd(3'd1, 32'h3);
    do_cmd(3'd3, 32'h0);
    chk("restart_flags", 128'(flags()), 128'(5'b11001));
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrun_reset_flags", 128'(flags()), 128'(5'b00000));
    chk("midrun_reset_ready", 128'(cmd_ready), 128'(1'b1));
    core_done = 1'b1; core_result = {4{32'hFFFFFFFF}};
    step();
    core_done = 1'b0;
    chk("late_done_ignored", 128'(flags()), 128'(5'b00000));
    rd_idx = 2'd0; step();
    chk("late_done_result", 128'(rd_data), 128'(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
